// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CTS,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_FRAME_BITS       = 10;
    localparam int UART_DEFAULT_BAUD_DIV = 104;

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and pulses tick at terminal count.
module baud_tick #(
    parameter int BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] TC = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == TC) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_flow.sv
// 8N1 serial transmitter with valid/ready byte intake and CTS-gated frame start.
module uart_tx_flow
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = UART_DEFAULT_BAUD_DIV,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [DATA_BITS-1:0] I,
    input  logic                 VALID,
    output logic                 READY,
    input  logic                 CTSN,
    output logic                 TX,
    output logic                 BUSY
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic [2:0]           idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 cts_meta_q, cts_sync_q;
    logic                 rdy_en_q;
    logic                 baud_clr;
    logic                 baud_en;
    logic                 bit_done;

    baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk  (CLK),
        .rst_n(RESETN),
        .clr  (baud_clr),
        .en   (baud_en),
        .tick (bit_done)
    );

    assign baud_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        idx_d    = idx_q;
        baud_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdy_en_q && VALID) begin
                    sreg_d  = I;
                    state_d = WAIT_CTS;
                end
            end
            WAIT_CTS: begin
                if (!cts_sync_q) begin
                    state_d  = START;
                    baud_clr = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    sreg_d = sreg_q >> 1;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so TX changes on the same edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sreg_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            cts_meta_q <= CTSN;
            cts_sync_q <= cts_meta_q;
            rdy_en_q   <= 1'b1;
        end
    end

    // rdy_en_q keeps READY low through reset even though state_q sits in IDLE.
    assign READY = rdy_en_q && (state_q == IDLE);
    assign TX    = tx_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_uart_tx_flow.sv
// Randomised and directed bench for uart_tx_flow against a frame-level line model.
module tb_uart_tx_flow;

    localparam int BD = 4;

    logic       CLK    = 1'b0;
    logic       RESETN = 1'b1;
    logic       VALID  = 1'b0;
    logic       CTSN   = 1'b0;
    logic [7:0] I      = 8'h00;
    logic       READY;
    logic       TX;
    logic       BUSY;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_flow #(
        .BAUD_DIV (BD),
        .DATA_BITS(8)
    ) dut (
        .CLK   (CLK),
        .RESETN(RESETN),
        .I     (I),
        .VALID (VALID),
        .READY (READY),
        .CTSN  (CTSN),
        .TX    (TX),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int w = 0;
        while (READY !== 1'b1 && w < 200) begin
            cyc();
            w++;
        end
        chk("send_ready", 32'(READY), 1);
        I     = b;
        VALID = 1'b1;
        cyc();
        VALID = 1'b0;
        I     = 8'($urandom);
        chk("acc_ready_low", 32'(READY), 0);
        chk("acc_busy", 32'(BUSY), 1);
    endtask

    // Expected line: start 0, data LSB first, stop 1, each held BD cycles.
    task automatic expect_frame(input logic [7:0] b, input int cts_hi_at, input int rst_at,
                                output int lat);
        logic [9:0] fr;
        fr  = {1'b1, b, 1'b0};
        lat = 0;
        while (TX !== 1'b0 && lat < 300) begin
            cyc();
            lat++;
        end
        if (TX !== 1'b0) begin
            chk("fall_timeout", 32'(TX), 0);
            return;
        end
        for (int i = 0; i < 10 * BD; i++) begin
            if (i == cts_hi_at) CTSN = 1'b1;
            if (i == rst_at) begin
                #2 RESETN = 1'b0;
                #1;
                chk("rst_tx", 32'(TX), 1);
                chk("rst_busy", 32'(BUSY), 0);
                chk("rst_ready", 32'(READY), 0);
                return;
            end
            chk($sformatf("frame_bit%0d", i / BD), 32'(TX), 32'(fr[i / BD]));
            chk("frame_busy", 32'(BUSY), 1);
            chk("frame_ready", 32'(READY), 0);
            cyc();
        end
        chk("end_ready", 32'(READY), 1);
        chk("end_busy", 32'(BUSY), 0);
        chk("end_tx", 32'(TX), 1);
    endtask

    task automatic hold_check(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            cyc();
            if (TX !== 1'b1 || BUSY !== 1'b1 || READY !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic idle_check(input string tag, input int n);
        int lows = 0;
        repeat (n) begin
            cyc();
            if (TX !== 1'b1 || BUSY !== 1'b0) lows++;
        end
        chk(tag, lows, 0);
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        int d;

        // reset with VALID asserted
        #2 RESETN = 1'b0;
        VALID = 1'b1;
        I     = 8'h55;
        repeat (3) cyc();
        chk("rst_tx0", 32'(TX), 1);
        chk("rst_busy0", 32'(BUSY), 0);
        chk("rst_ready0", 32'(READY), 0);
        VALID = 1'b0;
        #3 RESETN = 1'b1;
        cyc();
        chk("rel_ready", 32'(READY), 1);
        chk("rel_busy", 32'(BUSY), 0);
        idle_check("rel_no_frame", 20);

        // 0xA5 with CTS already clear
        send(8'hA5);
        expect_frame(8'hA5, -1, -1, lat);
        chk("a5_lat", lat, 1);

        // 0x3C held by CTS for 100 cycles
        CTSN = 1'b1;
        repeat (3) cyc();
        send(8'h3C);
        hold_check("cts_hold_3c", 100);
        CTSN = 1'b0;
        expect_frame(8'h3C, -1, -1, lat);
        chk("cts_lat_3c", lat, 3);

        // 0xFF with CTS raised during data bit 3, then 0x00 blocked
        send(8'hFF);
        expect_frame(8'hFF, BD * 4 + 1, -1, lat);
        chk("ff_lat", lat, 1);
        send(8'h00);
        hold_check("cts_hold_00", 20);
        CTSN = 1'b0;
        expect_frame(8'h00, -1, -1, lat);
        chk("cts_lat_00", lat, 3);

        // reset during data bit 5 of 0x81
        send(8'h81);
        expect_frame(8'h81, -1, BD * 6 + 1, lat);
        repeat (2) cyc();
        #3 RESETN = 1'b1;
        cyc();
        chk("rel2_ready", 32'(READY), 1);
        chk("rel2_tx", 32'(TX), 1);
        chk("rel2_busy", 32'(BUSY), 0);
        idle_check("rel2_no_residual", 30);

        // back-to-back with VALID held high
        I     = 8'h00;
        VALID = 1'b1;
        cyc();
        I = 8'hFF;
        expect_frame(8'h00, -1, -1, lat);
        chk("b2b_lat0", lat, 1);
        cyc();
        VALID = 1'b0;
        chk("b2b_busy", 32'(BUSY), 1);
        chk("b2b_ready", 32'(READY), 0);
        expect_frame(8'hFF, -1, -1, lat);
        chk("b2b_gap", lat + 1, 2);

        // random bytes with random CTS stalls
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            d = int'($urandom_range(0, 6));
            if (d > 0) begin
                CTSN = 1'b1;
                repeat (3) cyc();
            end
            send(b);
            if (d > 0) begin
                hold_check("rnd_hold", d);
                CTSN = 1'b0;
            end
            expect_frame(b, -1, -1, lat);
            chk("rnd_lat", lat, (d > 0) ? 3 : 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_flow.md
# uart_tx_flow

Serial 8N1 transmitter with a valid/ready upstream handshake and CTS flow control. It sits directly downstream of the board's free-running counter stage. That stage supplies payload bytes (e.g. a sampled counter slice) on a valid/ready port. This block drives the FTDI serial line on the icestick. It replaces the static counter-bit wiring of the modem pins with real framed output.

## Interface
Parameters:
- BAUD_DIV, 104: CLK cycles per serial bit (12 MHz / 115200). Legal range ≥ 2.
- DATA_BITS, 8: payload bits per frame. Fixed at 8 for this revision.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESETN  in  1  asynchronous, active-low reset. Asserted: all state cleared immediately. Released: synchronously to CLK.
- I  in  8  payload byte, sampled on handshake.
- VALID  in  1  upstream has a byte on I.
- READY  out  1  block accepts a byte this cycle.
- CTSN  in  1  clear-to-send, active-low, asynchronous to CLK.
- TX  out  1  serial line, idle high.
- BUSY  out  1  high from acceptance until stop bit completes.

## Operation
- States: IDLE, WAIT_CTS, START, DATA, STOP.
- IDLE: READY=1, TX=1, BUSY=0. If VALID=1, the byte is accepted: I is loaded into the shift register and the next state is WAIT_CTS.
- WAIT_CTS:
  - READY=0, BUSY=1, TX=1.
  - Remains here while synchronized CTSN=1.
  - Synchronized CTSN=0: go to START and clear the baud counter.
- START: TX=0 for BAUD_DIV cycles, then DATA with bit index 0.
- DATA:
  - TX = shift register LSB, held BAUD_DIV cycles per bit.
  - After each bit: shift right, increment the 3-bit index.
  - After index 7 completes: go to STOP.
- STOP: TX=1 for BAUD_DIV cycles, then IDLE.
- CTSN is checked only in WAIT_CTS. Deassertion mid-frame never aborts or stretches the current frame.
- I and VALID are ignored outside IDLE. Upstream must hold I stable only in the handshake cycle.
- Baud counter:
  - Width $clog2(BAUD_DIV).
  - Counts 0..BAUD_DIV-1.
  - Terminal count produces a one-cycle bit_done pulse and wraps to 0.
- Reset values: state=IDLE, TX=1, BUSY=0, shift register=0, counters=0, CTS synchronizer=1 (not clear).
  - READY=0 while RESETN is low.
  - READY=1 from the first cycle after release.
- Reset mid-frame: TX returns to 1 asynchronously. The in-flight byte is discarded and not retransmitted.

## Timing
- Handshake at edge k → state WAIT_CTS in cycle k+1. READY=0 and BUSY=1 from that cycle.
- CTSN passes through a 2-flop synchronizer.
- If CTSN is held low ≥2 cycles before acceptance: START entered at edge k+1, and TX falls in cycle k+2.
- If CTSN falls at edge c during WAIT_CTS: TX falls in cycle c+3.
- Frame duration: exactly 10·BAUD_DIV cycles from TX falling to READY rising. READY rises in the first cycle after the stop bit ends.
- Back-to-back with VALID held high:
  - The next byte is accepted in the first READY cycle.
  - Idle-high gap between stop bit and next start bit is 1 cycle (IDLE) plus the CTS path.
- TX and BUSY are registered outputs. READY is decoded from the state register.

## Structure
- Shared package uart_pkg holds:
  - the state enum uart_tx_state_t (IDLE, WAIT_CTS, START, DATA, STOP);
  - UART_FRAME_BITS=10;
  - UART_DEFAULT_BAUD_DIV=104.
- One sub-module, baud_tick:
  - parameterized BAUD_DIV counter;
  - synchronous clear input and enable input;
  - one-cycle tick output at terminal count.
- The CTS synchronizer is inline in uart_tx_flow.

## Test plan
- Reset: RESETN low with VALID=1 → TX=1, BUSY=0, READY=0. After release → READY=1 next cycle, no frame sent.
- BAUD_DIV=4, CTSN=0, send 0xA5 →
  - TX = 0 for 4 cycles;
  - then bits 1,0,1,0,0,1,0,1, each for 4 cycles;
  - then 1 for 4 cycles;
  - READY returns 40 cycles after TX falls.
- CTSN=1, send 0x3C → TX stays 1, BUSY=1, READY=0 for 100 cycles. CTSN→0 → start bit begins exactly 3 cycles later, and the frame carries 0x3C.
- Send 0xFF, toggle CTSN=1 during DATA bit 3 → frame completes unchanged. A second byte, 0x00, is held in WAIT_CTS until CTSN=0.
- RESETN pulsed low during DATA bit 5 of 0x81 → TX=1 immediately. After release: IDLE, READY=1, no residual bits.
- VALID held high with 0x00 then 0xFF, CTSN=0, BAUD_DIV=4 → two contiguous frames. The idle gap between stop-bit end and next start bit is exactly 2 cycles.
